// File: rtl/udiv_sched.sv
// udiv_sched: round-robin scheduler sharing one fully pipelined unsigned
// divider between NREQ requesters. A tag pipe runs alongside the divider so
// each result is steered back to its owner; per-requester credits cap the
// number of outstanding operations.

// One restoring-division iteration: shift in the next dividend bit, subtract
// the divisor when it fits, shift the quotient bit in.
module udiv_sched_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] trial;
    assign trial = {rem_i, q_i[WIDTH-1]};

    // trial < 2*d always holds, so the difference fits in WIDTH bits
    always_comb begin
        if (trial >= {1'b0, d_i}) begin
            rem_o = trial[WIDTH-1:0] - d_i;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = trial[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

module udiv_sched #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4,
    localparam int IFW    = $clog2(NREQ*MAX_OUT+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       res_valid,
    output logic [WIDTH-1:0]      res_quotient,
    output logic [WIDTH-1:0]      res_remainder,
    output logic                  res_divzero,
    output logic [IFW-1:0]        in_flight,
    output logic                  busy
);
    // WIDTH iterations: WIDTH-1 register stages plus the result register
    localparam int STAGES = WIDTH - 1;
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW     = $clog2(MAX_OUT + 1);

    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt [NREQ];
    logic [NREQ-1:0]  elig;
    logic             gnt_found;
    logic [IW-1:0]    gnt_idx;
    logic             issue;
    logic [WIDTH-1:0] iss_dvd, iss_dvs;

    // divider datapath
    logic [WIDTH-1:0] in_rem [WIDTH];
    logic [WIDTH-1:0] in_q   [WIDTH];
    logic [WIDTH-1:0] in_d   [WIDTH];
    logic [WIDTH-1:0] s_rem  [WIDTH];
    logic [WIDTH-1:0] s_q    [WIDTH];
    logic [WIDTH-1:0] p_rem  [1:STAGES];
    logic [WIDTH-1:0] p_q    [1:STAGES];
    logic [WIDTH-1:0] p_d    [1:STAGES];

    // tag pipe aligned with the divider stages
    logic [STAGES:1]  vld_pipe;
    logic [STAGES:1]  dz_pipe;
    logic [IW-1:0]    idx_pipe [1:STAGES];
    logic [WIDTH-1:0] dvd_pipe [1:STAGES];

    function automatic int rr_idx(int p, int k);
        return (p + k >= NREQ) ? p + k - NREQ : p + k;
    endfunction

    // Eligibility and round-robin pick. A result leaving this cycle frees its
    // credit immediately, so a full requester can refill on its result cycle.
    always_comb begin
        elig      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++)
            elig[i] = req_valid[i] && ((cnt[i] < CW'(MAX_OUT)) || res_valid[i]);
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && elig[rr_idx(int'(ptr), k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(rr_idx(int'(ptr), k));
            end
        end
    end

    assign issue     = gnt_found && !reset;
    assign req_ready = issue ? (NREQ'(1) << gnt_idx) : '0;
    assign iss_dvd   = req_dividend[gnt_idx*WIDTH +: WIDTH];
    assign iss_dvs   = req_divisor[gnt_idx*WIDTH +: WIDTH];
    assign busy      = (in_flight != '0);

    // iteration k consumes stage k (stage 0 is the issuing operands)
    for (genvar k = 0; k < WIDTH; k++) begin : g_step
        if (k == 0) begin : g_head
            assign in_rem[k] = '0;
            assign in_q[k]   = iss_dvd;
            assign in_d[k]   = iss_dvs;
        end else begin : g_body
            assign in_rem[k] = p_rem[k];
            assign in_q[k]   = p_q[k];
            assign in_d[k]   = p_d[k];
        end
        udiv_sched_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (in_rem[k]),
            .q_i   (in_q[k]),
            .d_i   (in_d[k]),
            .rem_o (s_rem[k]),
            .q_o   (s_q[k])
        );
    end

    // datapath and tag payload shift every cycle; bubbles carry junk
    always_ff @(posedge clk) begin
        for (int k = 1; k <= STAGES; k++) begin
            p_rem[k] <= s_rem[k-1];
            p_q[k]   <= s_q[k-1];
            p_d[k]   <= in_d[k-1];
        end
        idx_pipe[1] <= gnt_idx;
        dz_pipe[1]  <= (iss_dvs == '0);
        dvd_pipe[1] <= iss_dvd;
        for (int k = 2; k <= STAGES; k++) begin
            idx_pipe[k] <= idx_pipe[k-1];
            dz_pipe[k]  <= dz_pipe[k-1];
            dvd_pipe[k] <= dvd_pipe[k-1];
        end
    end

    // tag valid bits; cleared on reset so in-flight work is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            for (int k = 2; k <= STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // result register: last iteration plus divide-by-zero override
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid     <= '0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_divzero   <= 1'b0;
        end else begin
            res_valid <= vld_pipe[STAGES] ? (NREQ'(1) << idx_pipe[STAGES]) : '0;
            if (vld_pipe[STAGES]) begin
                res_quotient  <= dz_pipe[STAGES] ? '1 : s_q[STAGES];
                res_remainder <= dz_pipe[STAGES] ? dvd_pipe[STAGES] : s_rem[STAGES];
                res_divzero   <= dz_pipe[STAGES];
            end
        end
    end

    // round-robin pointer advances past the granted requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (issue)
            ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // per-requester credits: +1 on issue, -1 on result, hold on both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({issue && (int'(gnt_idx) == i), res_valid[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // global occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            case ({issue, |res_valid})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // credit sanity: a result always has a credit behind it, never over cap
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                assert (!res_valid[i] || cnt[i] != '0);
                assert (cnt[i] <= CW'(MAX_OUT));
            end
        end
    end
endmodule
